// File: rtl/chart_sequencer_if.sv
// -----------------------------------------------------------------------------
// chart_sequencer_if
// Bundles the control, chart-write and launch/status signals of
// chart_sequencer. Clock and reset stay as plain ports on the module.
//
// Signal summary (directions are seen from the sequencer, i.e. the slave):
//   step_tick_i  in   one-cycle pulse per chart step
//   start_i      in   start chart from step 0 (acts only in IDLE)
//   stop_i       in   abort to IDLE, highest priority
//   pause_i      in   level; while high in RUN ticks are ignored
//   loop_i       in   level; sampled at the last step, 1 = wrap to step 0
//   len_i        in   index of the last chart step, captured on start
//   lane_en_i    in   per-lane launch mask, applied at launch time
//   wr_en_i      in   chart RAM write strobe
//   wr_addr_i    in   chart RAM write address
//   wr_data_i    in   step pattern, bit n launches lane n
//   launch_o     out  one-cycle launch pulses, one bit per lane
//   busy_o       out  high in RUN or PAUSE
//   paused_o     out  high in PAUSE
//   done_o       out  one-cycle pulse when a non-looping chart finishes
//   step_idx_o   out  index of the next step to be issued
// -----------------------------------------------------------------------------
interface chart_sequencer_if #(
    parameter int LANES = 4,
    parameter int ADDRW = 6
);
    logic             step_tick_i;
    logic             start_i;
    logic             stop_i;
    logic             pause_i;
    logic             loop_i;
    logic [ADDRW-1:0] len_i;
    logic [LANES-1:0] lane_en_i;
    logic             wr_en_i;
    logic [ADDRW-1:0] wr_addr_i;
    logic [LANES-1:0] wr_data_i;
    logic [LANES-1:0] launch_o;
    logic             busy_o;
    logic             paused_o;
    logic             done_o;
    logic [ADDRW-1:0] step_idx_o;

    // Driver side: timing/control logic and the chart loader.
    modport master (
        output step_tick_i, start_i, stop_i, pause_i, loop_i, len_i,
               lane_en_i, wr_en_i, wr_addr_i, wr_data_i,
        input  launch_o, busy_o, paused_o, done_o, step_idx_o
    );

    // Sequencer side.
    modport slave (
        input  step_tick_i, start_i, stop_i, pause_i, loop_i, len_i,
               lane_en_i, wr_en_i, wr_addr_i, wr_data_i,
        output launch_o, busy_o, paused_o, done_o, step_idx_o
    );
endinterface

// File: rtl/chart_sequencer.sv
// -----------------------------------------------------------------------------
// chart_sequencer
// Plays a step chart stored in a small on-chip RAM and issues one-cycle
// launch pulses to the four arrow lanes, one chart step per rhythm tick.
//
// Ports:
//   clk_i    in   system clock
//   rst_ni   in   asynchronous active-low reset
//   seq_bus  slave modport of chart_sequencer_if (control, chart write port,
//            launch pulses and status)
//
// Timing: a tick accepted in RUN reads the chart entry for the current step;
// the masked pattern appears on launch_o during the following cycle only.
// done_o for a non-looping chart lines up with that final launch, while the
// FSM is already back in IDLE.
// -----------------------------------------------------------------------------
module chart_sequencer #(
    parameter int LANES = 4,
    parameter int ADDRW = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    chart_sequencer_if.slave   seq_bus
);

    localparam int DEPTH = 2 ** ADDRW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           r_state;
    logic [ADDRW-1:0] r_step_idx;
    logic [ADDRW-1:0] r_len_q;
    logic [LANES-1:0] r_rd_q;
    logic             r_fire_q;
    logic             r_done_q;

    // Chart storage; intentionally not reset, software loads it before use.
    logic [LANES-1:0] r_mem [DEPTH];

    logic             w_last_step;
    logic [LANES-1:0] w_launch;

    // Chart RAM write port, open in every state.
    always_ff @(posedge clk_i) begin
        if (seq_bus.wr_en_i) begin
            r_mem[seq_bus.wr_addr_i] <= seq_bus.wr_data_i;
        end
    end

    assign w_last_step = (r_step_idx == r_len_q);

    // Sequencer FSM with read port, fire and done strobes.
    // The chart read is a non-blocking sample of r_mem, so a same-cycle write
    // to the same address is seen only on the next visit (old data returned).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_step_idx <= {ADDRW{1'b0}};
            r_len_q    <= {ADDRW{1'b0}};
            r_rd_q     <= {LANES{1'b0}};
            r_fire_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            // Both strobes are single-cycle unless re-armed below.
            r_fire_q <= 1'b0;
            r_done_q <= 1'b0;
            if (seq_bus.stop_i) begin
                // Stop overrides everything, including a tick this cycle.
                r_state    <= ST_IDLE;
                r_step_idx <= {ADDRW{1'b0}};
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (seq_bus.start_i) begin
                            r_len_q    <= seq_bus.len_i;
                            r_step_idx <= {ADDRW{1'b0}};
                            r_state    <= ST_RUN;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (seq_bus.pause_i) begin
                            // A tick coinciding with pause entry is dropped.
                            r_state <= ST_PAUSE;
                        end else if (seq_bus.step_tick_i) begin
                            r_rd_q   <= r_mem[r_step_idx];
                            r_fire_q <= 1'b1;
                            if (w_last_step) begin
                                // Wrap happens only here, never by overflow.
                                r_step_idx <= {ADDRW{1'b0}};
                                if (seq_bus.loop_i) begin
                                    r_state <= ST_RUN;
                                end else begin
                                    r_state  <= ST_IDLE;
                                    r_done_q <= 1'b1;
                                end
                            end else begin
                                r_step_idx <= r_step_idx + {{(ADDRW-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_PAUSE: begin
                        // Resume without issuing; the next tick plays the held step.
                        if (!seq_bus.pause_i) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_PAUSE;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_step_idx <= {ADDRW{1'b0}};
                    end
                endcase
            end
        end
    end

    // The lane mask is applied in the launch cycle, not the tick cycle.
    assign w_launch = r_fire_q ? (r_rd_q & seq_bus.lane_en_i) : {LANES{1'b0}};

    assign seq_bus.launch_o   = w_launch;
    assign seq_bus.busy_o     = (r_state != ST_IDLE);
    assign seq_bus.paused_o   = (r_state == ST_PAUSE);
    assign seq_bus.done_o     = r_done_q;
    assign seq_bus.step_idx_o = r_step_idx;

endmodule

// File: tb/tb_chart_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chart_sequencer
// Self-checking bench for chart_sequencer. Directed scenarios follow the
// chart behaviour; the random scenario predicts each tick's launch from the
// chart contents with plain modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_chart_sequencer;

    localparam int LANES = 4;
    localparam int ADDRW = 6;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    chart_sequencer_if #(.LANES(LANES), .ADDRW(ADDRW)) sb ();

    chart_sequencer #(.LANES(LANES), .ADDRW(ADDRW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .seq_bus (sb)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Bench-side copy of what has been written into the chart.
    logic [3:0] chart [DEPTH];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_step(input int a, input logic [3:0] d);
        sb.wr_en_i   = 1'b1;
        sb.wr_addr_i = 6'(a);
        sb.wr_data_i = d;
        cyc();
        sb.wr_en_i = 1'b0;
        chart[a]   = d;
    endtask

    task automatic start_chart(input int len, input logic lp);
        sb.len_i   = 6'(len);
        sb.loop_i  = lp;
        sb.start_i = 1'b1;
        cyc();
        sb.start_i = 1'b0;
    endtask

    task automatic tick_once();
        sb.step_tick_i = 1'b1;
        cyc();
        sb.step_tick_i = 1'b0;
    endtask

    task automatic stop_seq();
        sb.stop_i = 1'b1;
        cyc();
        sb.stop_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sb.step_tick_i = 1'b0; sb.start_i = 1'b0; sb.stop_i = 1'b0;
        sb.pause_i = 1'b0; sb.loop_i = 1'b0; sb.len_i = 6'd0;
        sb.lane_en_i = 4'hF; sb.wr_en_i = 1'b0; sb.wr_addr_i = 6'd0;
        sb.wr_data_i = 4'h0;
        #3;
        n_total++; if (sb.launch_o !== 4'h0) $display("FAIL reset_launch got %b expected 0000", sb.launch_o); else n_pass++;
        n_total++; if (sb.busy_o !== 1'b0) $display("FAIL reset_busy got %b expected 0", sb.busy_o); else n_pass++;
        n_total++; if (sb.paused_o !== 1'b0) $display("FAIL reset_paused got %b expected 0", sb.paused_o); else n_pass++;
        n_total++; if (sb.done_o !== 1'b0) $display("FAIL reset_done got %b expected 0", sb.done_o); else n_pass++;
        n_total++; if (sb.step_idx_o !== 6'd0) $display("FAIL reset_step got %0d expected 0", sb.step_idx_o); else n_pass++;
        #9 rst_n = 1'b1;
        write_step(0, 4'b0001); write_step(1, 4'b0010);
        write_step(2, 4'b0100); write_step(3, 4'b1000);
        start_chart(3, 1'b1);
        repeat (3) tick_once();
        n_total++; if (sb.step_idx_o !== 6'd3) $display("FAIL midrun_step got %0d expected 3", sb.step_idx_o); else n_pass++;
        tick_once();
        // Asynchronous reset during the launch cycle of step 3.
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (sb.launch_o !== 4'h0) $display("FAIL async_rst_launch got %b expected 0000", sb.launch_o); else n_pass++;
        n_total++; if (sb.busy_o !== 1'b0) $display("FAIL async_rst_busy got %b expected 0", sb.busy_o); else n_pass++;
        n_total++; if (sb.step_idx_o !== 6'd0) $display("FAIL async_rst_step got %0d expected 0", sb.step_idx_o); else n_pass++;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick_once();
            n_total++; if (sb.launch_o !== 4'h0) $display("FAIL post_rst_tick%0d got %b expected 0000", k, sb.launch_o); else n_pass++;
            n_total++; if (sb.busy_o !== 1'b0) $display("FAIL post_rst_busy%0d got %b expected 0", k, sb.busy_o); else n_pass++;
        end
    endtask

    task automatic test_basic();
        sb.lane_en_i = 4'hF;
        start_chart(3, 1'b0);
        n_total++; if (sb.busy_o !== 1'b1) $display("FAIL basic_busy got %b expected 1", sb.busy_o); else n_pass++;
        n_total++; if (sb.step_idx_o !== 6'd0) $display("FAIL basic_step0 got %0d expected 0", sb.step_idx_o); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            repeat (9) cyc();
            n_total++; if (sb.launch_o !== 4'h0) $display("FAIL basic_quiet%0d got %b expected 0000", k, sb.launch_o); else n_pass++;
            tick_once();
            n_total++; if (sb.launch_o !== chart[k]) $display("FAIL basic_launch%0d got %b expected %b", k, sb.launch_o, chart[k]); else n_pass++;
            n_total++; if (sb.done_o !== (k == 3)) $display("FAIL basic_done%0d got %b expected %b", k, sb.done_o, (k == 3)); else n_pass++;
            cyc();
            n_total++; if (sb.launch_o !== 4'h0) $display("FAIL basic_oneshot%0d got %b expected 0000", k, sb.launch_o); else n_pass++;
            n_total++; if (sb.done_o !== 1'b0) $display("FAIL basic_done_clr%0d got %b expected 0", k, sb.done_o); else n_pass++;
        end
        n_total++; if (sb.busy_o !== 1'b0) $display("FAIL basic_idle got %b expected 0", sb.busy_o); else n_pass++;
        tick_once();
        n_total++; if (sb.launch_o !== 4'h0) $display("FAIL basic_fifth got %b expected 0000", sb.launch_o); else n_pass++;
    endtask

    task automatic test_loop_mask();
        sb.lane_en_i = 4'b1101;
        start_chart(3, 1'b1);
        for (int k = 0; k < 8; k++) begin
            n_total++; if (sb.step_idx_o !== 6'(k % 4)) $display("FAIL loop_step%0d got %0d expected %0d", k, sb.step_idx_o, k % 4); else n_pass++;
            tick_once();
            n_total++; if (sb.launch_o !== (chart[k % 4] & 4'b1101)) $display("FAIL loop_launch%0d got %b expected %b", k, sb.launch_o, chart[k % 4] & 4'b1101); else n_pass++;
            n_total++; if (sb.done_o !== 1'b0) $display("FAIL loop_done%0d got %b expected 0", k, sb.done_o); else n_pass++;
        end
        n_total++; if (sb.busy_o !== 1'b1) $display("FAIL loop_busy got %b expected 1", sb.busy_o); else n_pass++;
        stop_seq();
    endtask

    task automatic test_pause();
        sb.lane_en_i = 4'hF;
        start_chart(3, 1'b0);
        tick_once();
        tick_once();
        sb.pause_i = 1'b1;
        cyc();
        n_total++; if (sb.paused_o !== 1'b1) $display("FAIL pause_flag got %b expected 1", sb.paused_o); else n_pass++;
        n_total++; if (sb.busy_o !== 1'b1) $display("FAIL pause_busy got %b expected 1", sb.busy_o); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick_once();
            n_total++; if (sb.launch_o !== 4'h0) $display("FAIL pause_launch%0d got %b expected 0000", k, sb.launch_o); else n_pass++;
            n_total++; if (sb.step_idx_o !== 6'd2) $display("FAIL pause_step%0d got %0d expected 2", k, sb.step_idx_o); else n_pass++;
        end
        sb.pause_i = 1'b0;
        cyc();
        n_total++; if (sb.paused_o !== 1'b0) $display("FAIL resume_flag got %b expected 0", sb.paused_o); else n_pass++;
        tick_once();
        n_total++; if (sb.launch_o !== 4'b0100) $display("FAIL resume_launch got %b expected 0100", sb.launch_o); else n_pass++;
        stop_seq();
    endtask

    task automatic test_stop();
        sb.lane_en_i = 4'hF;
        start_chart(3, 1'b1);
        tick_once();
        n_total++; if (sb.launch_o !== 4'b0001) $display("FAIL stop_pre got %b expected 0001", sb.launch_o); else n_pass++;
        sb.step_tick_i = 1'b1; sb.stop_i = 1'b1;
        cyc();
        sb.step_tick_i = 1'b0; sb.stop_i = 1'b0;
        n_total++; if (sb.launch_o !== 4'h0) $display("FAIL stop_suppress got %b expected 0000", sb.launch_o); else n_pass++;
        n_total++; if (sb.busy_o !== 1'b0) $display("FAIL stop_busy got %b expected 0", sb.busy_o); else n_pass++;
        n_total++; if (sb.step_idx_o !== 6'd0) $display("FAIL stop_step got %0d expected 0", sb.step_idx_o); else n_pass++;
        n_total++; if (sb.done_o !== 1'b0) $display("FAIL stop_done got %b expected 0", sb.done_o); else n_pass++;
        sb.start_i = 1'b1; sb.stop_i = 1'b1;
        cyc();
        sb.start_i = 1'b0; sb.stop_i = 1'b0;
        n_total++; if (sb.busy_o !== 1'b0) $display("FAIL stop_over_start got %b expected 0", sb.busy_o); else n_pass++;
        tick_once();
        n_total++; if (sb.launch_o !== 4'h0) $display("FAIL stop_idle_tick got %b expected 0000", sb.launch_o); else n_pass++;
        // One-step chart: stop on its only tick gives neither launch nor done.
        start_chart(0, 1'b0);
        sb.step_tick_i = 1'b1; sb.stop_i = 1'b1;
        cyc();
        sb.step_tick_i = 1'b0; sb.stop_i = 1'b0;
        n_total++; if (sb.done_o !== 1'b0) $display("FAIL stop_last_done got %b expected 0", sb.done_o); else n_pass++;
        start_chart(0, 1'b0);
        tick_once();
        n_total++; if (sb.launch_o !== chart[0]) $display("FAIL onestep_launch got %b expected %b", sb.launch_o, chart[0]); else n_pass++;
        n_total++; if (sb.done_o !== 1'b1) $display("FAIL onestep_done got %b expected 1", sb.done_o); else n_pass++;
        n_total++; if (sb.busy_o !== 1'b0) $display("FAIL onestep_idle got %b expected 0", sb.busy_o); else n_pass++;
    endtask

    task automatic test_write_hazard();
        logic [3:0] old2;
        sb.lane_en_i = 4'hF;
        start_chart(3, 1'b1);
        tick_once();
        tick_once();
        old2 = chart[2];
        sb.step_tick_i = 1'b1;
        sb.wr_en_i = 1'b1; sb.wr_addr_i = 6'd2; sb.wr_data_i = 4'hF;
        cyc();
        sb.step_tick_i = 1'b0; sb.wr_en_i = 1'b0;
        chart[2] = 4'hF;
        n_total++; if (sb.launch_o !== old2) $display("FAIL hazard_old got %b expected %b", sb.launch_o, old2); else n_pass++;
        for (int k = 3; k < 7; k++) begin
            tick_once();
            n_total++; if (sb.launch_o !== chart[k % 4]) $display("FAIL hazard_pass%0d got %b expected %b", k, sb.launch_o, chart[k % 4]); else n_pass++;
        end
        stop_seq();
    endtask

    task automatic test_random();
        int         len;
        logic       lp;
        int         nticks;
        int         gap;
        logic [3:0] exp_l;
        logic       exp_d;
        int         exp_idx;
        for (int it = 0; it < 6; it++) begin
            len = (it == 0) ? 63 : int'($urandom_range(0, 15));
            lp  = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int a = 0; a <= len; a++) write_step(a, 4'($urandom));
            start_chart(len, lp);
            nticks = lp ? 2 * (len + 1) + 1 : len + 2;
            for (int k = 0; k < nticks; k++) begin
                sb.step_tick_i = 1'b1;
                cyc();
                // Mask changes after the tick edge must still affect the launch.
                sb.lane_en_i = 4'($urandom);
                #1;
                exp_l   = (lp || k <= len) ? (chart[k % (len + 1)] & sb.lane_en_i) : 4'h0;
                exp_d   = !lp && (k == len);
                exp_idx = (lp || k < len) ? (k + 1) % (len + 1) : 0;
                n_total++; if (sb.launch_o !== exp_l) $display("FAIL rand_launch it%0d k%0d got %b expected %b", it, k, sb.launch_o, exp_l); else n_pass++;
                n_total++; if (sb.done_o !== exp_d) $display("FAIL rand_done it%0d k%0d got %b expected %b", it, k, sb.done_o, exp_d); else n_pass++;
                n_total++; if (sb.step_idx_o !== 6'(exp_idx)) $display("FAIL rand_step it%0d k%0d got %0d expected %0d", it, k, sb.step_idx_o, exp_idx); else n_pass++;
                gap = int'($urandom_range(0, 2));
                if (gap > 0) begin
                    sb.step_tick_i = 1'b0;
                    cyc();
                    n_total++; if (sb.launch_o !== 4'h0) $display("FAIL rand_gap it%0d k%0d got %b expected 0000", it, k, sb.launch_o); else n_pass++;
                    repeat (gap - 1) cyc();
                end
            end
            sb.step_tick_i = 1'b0;
            stop_seq();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop_mask();
        test_pause();
        test_stop();
        test_write_hazard();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
